// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small combinational
// gate block in ascending order, holds each vector for SETTLE cycles, samples
// the block's output once per row and compares it against the EXPECT table.
// Optional feature macro: TT_CHECKER_CAPTURE_EN adds the 'observed' port,
// which records the raw sampled value of every row.
module truth_table_checker #(
   parameter int                    N_IN   = 2,
   parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1001,
   parameter int                    SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_in,
   output logic [N_IN-1:0]       vec_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_IN:0]         err_count,
   output logic [(1<<N_IN)-1:0]  fail_mask
`ifdef TT_CHECKER_CAPTURE_EN
   ,
   output logic [(1<<N_IN)-1:0]  observed
`endif
);

   localparam int                ROWS     = 1 << N_IN;
   localparam int                SET_EFF  = (SETTLE < 1) ? 1 : SETTLE;
   localparam int                CW       = $clog2(SET_EFF + 1);
   localparam logic [CW-1:0]     CNT_INIT = CW'(SET_EFF);
   localparam logic [N_IN-1:0]   LAST     = N_IN'(ROWS - 1);
   localparam logic [N_IN:0]     ERR_MAX  = (N_IN + 1)'(ROWS);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t            state, state_d;
   logic [N_IN-1:0]   idx, idx_d;
   logic [N_IN-1:0]   vec_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [N_IN:0]     err_d;
   logic [ROWS-1:0]   mask_d;
`ifdef TT_CHECKER_CAPTURE_EN
   logic [ROWS-1:0]   obs_d;
`endif

   // State and result registers; reset abandons any sweep in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         vec_out   <= '0;
         cnt       <= '0;
         err_count <= '0;
         fail_mask <= '0;
`ifdef TT_CHECKER_CAPTURE_EN
         observed  <= '0;
`endif
      end else begin
         state     <= state_d;
         idx       <= idx_d;
         vec_out   <= vec_d;
         cnt       <= cnt_d;
         err_count <= err_d;
         fail_mask <= mask_d;
`ifdef TT_CHECKER_CAPTURE_EN
         observed  <= obs_d;
`endif
      end
   end

   // Next-state and next-result logic for the sweep sequencer.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      vec_d   = vec_out;
      cnt_d   = cnt;
      err_d   = err_count;
      mask_d  = fail_mask;
`ifdef TT_CHECKER_CAPTURE_EN
      obs_d   = observed;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            // Results from a finished sweep clear on the restarting edge.
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               vec_d   = '0;
               cnt_d   = CNT_INIT;
               err_d   = '0;
               mask_d  = '0;
`ifdef TT_CHECKER_CAPTURE_EN
               obs_d   = '0;
`endif
            end
         end
         S_SETTLE: begin
            cnt_d = cnt - 1'b1;
            if (cnt == CW'(1)) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (s_in != EXPECT[idx]) begin
               if (err_count != ERR_MAX) err_d = err_count + 1'b1;
               mask_d[idx] = 1'b1;
            end
`ifdef TT_CHECKER_CAPTURE_EN
            obs_d[idx] = s_in;
`endif
            if (idx != LAST) begin
               idx_d   = idx + 1'b1;
               vec_d   = idx + 1'b1;
               cnt_d   = CNT_INIT;
               state_d = S_SETTLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
   assign done = (state == S_DONE);
   assign pass = (state == S_DONE) && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a behavioural gate (a 4-entry truth table
// indexed by vec_out) feeds s_in; expected results come from comparing that
// table with EXPECT row by row and from the row timing arithmetic.
module tb_truth_table_checker;

   localparam int          N_IN   = 2;
   localparam int          ROWS   = 4;
   localparam int          S      = 1;
   localparam logic [3:0]  EXP_TT = 4'b1001;
   localparam int          SWEEP  = ROWS * (S + 1);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        s_in;
   logic [1:0]  vec_out;
   logic        busy, done, pass;
   logic [2:0]  err_count;
   logic [3:0]  fail_mask;
`ifdef TT_CHECKER_CAPTURE_EN
   logic [3:0]  observed;
`endif

   logic [3:0]  dut_tt = EXP_TT;
   int          n_checks = 0;
   int          n_fail = 0;

   truth_table_checker #(.N_IN(N_IN), .EXPECT(EXP_TT), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .s_in(s_in), .vec_out(vec_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_mask(fail_mask)
`ifdef TT_CHECKER_CAPTURE_EN
      , .observed(observed)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural gate under check.
   always_comb s_in = dut_tt[vec_out];

   function automatic int popcnt(input logic [3:0] v);
      int c = 0;
      for (int i = 0; i < 4; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full sweep; inject >= 0 pulses start so that it lands on edge k+inject+1.
   task automatic do_sweep(input logic [3:0] tt, input int inject, input string nm);
      logic [3:0] bad;
      logic [3:0] part;
      int         rows_done;
      bad = tt ^ EXP_TT;
      dut_tt = tt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < SWEEP; j++) begin
         rows_done = j / (S + 1);
         part = bad & 4'((1 << rows_done) - 1);
         n_checks++;
         if (vec_out !== 2'(j / (S + 1)) || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL %s run j=%0d: vec=%0d busy=%b done=%b pass=%b, want vec=%0d busy=1 done=0 pass=0",
                     nm, j, vec_out, busy, done, pass, j / (S + 1));
         end
         n_checks++;
         if (err_count !== 3'(popcnt(part)) || fail_mask !== part) begin
            n_fail++;
            $display("FAIL %s partial j=%0d: err=%0d mask=%b, want err=%0d mask=%b",
                     nm, j, err_count, fail_mask, popcnt(part), part);
         end
         start = (j == inject) ? 1'b1 : 1'b0;
         step();
      end
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || vec_out !== 2'd3) begin
         n_fail++;
         $display("FAIL %s done_edge: done=%b busy=%b vec=%0d, want done=1 busy=0 vec=3",
                  nm, done, busy, vec_out);
      end
      n_checks++;
      if (err_count !== 3'(popcnt(bad)) || fail_mask !== bad || pass !== (bad == 4'b0)) begin
         n_fail++;
         $display("FAIL %s result: err=%0d mask=%b pass=%b, want err=%0d mask=%b pass=%b",
                  nm, err_count, fail_mask, pass, popcnt(bad), bad, bad == 4'b0);
      end
`ifdef TT_CHECKER_CAPTURE_EN
      n_checks++;
      if (observed !== tt) begin
         n_fail++;
         $display("FAIL %s observed: got %b want %b", nm, observed, tt);
      end
`endif
      // Results must hold in DONE while start stays low.
      step();
      step();
      n_checks++;
      if (done !== 1'b1 || err_count !== 3'(popcnt(bad)) || fail_mask !== bad) begin
         n_fail++;
         $display("FAIL %s hold: done=%b err=%0d mask=%b, want 1 %0d %b",
                  nm, done, err_count, fail_mask, popcnt(bad), bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || vec_out !== 2'd0 ||
          err_count !== 3'd0 || fail_mask !== 4'd0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b pass=%b vec=%0d err=%0d mask=%b, want all zero",
                  busy, done, pass, vec_out, err_count, fail_mask);
      end
   endtask

   task automatic test_correct();      do_sweep(EXP_TT, -1, "correct");  endtask
   task automatic test_tied0();        do_sweep(4'b0000, -1, "tied0");   endtask
   task automatic test_tied1();        do_sweep(4'b1111, -1, "tied1");   endtask
   task automatic test_start_ignored(); do_sweep(4'b0010, 2, "busy_start"); endtask

   task automatic test_mid_reset();
      dut_tt = 4'b0000;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 2 * (S + 1); j++) step();
      n_checks++;
      if (vec_out !== 2'd2 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset pre: vec=%0d busy=%b, want vec=2 busy=1", vec_out, busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 2'd0 || err_count !== 3'd0 || fail_mask !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_reset post: busy=%b done=%b vec=%0d err=%0d mask=%b, want zeros",
                  busy, done, vec_out, err_count, fail_mask);
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || vec_out !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_reset idle: busy=%b vec=%0d, want busy=0 vec=0", busy, vec_out);
      end
      do_sweep(EXP_TT, -1, "after_reset");
   endtask

   task automatic test_restart();
      do_sweep(4'b0000, -1, "restart_a");
      do_sweep(EXP_TT, -1, "restart_b");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++)
         do_sweep(4'($urandom_range(0, 15)), (r % 2 == 1) ? int'($urandom_range(0, SWEEP - 1)) : -1, "random");
   endtask

   initial begin
      test_reset();
      test_correct();
      test_tied0();
      test_tied1();
      test_start_ignored();
      test_mid_reset();
      test_restart();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential harness stage wrapped around a small combinational gate block, such as the 2-input XNOR-equivalent circuit in this guide.
- Upstream role: drives the block's inputs through every input combination in ascending binary order.
- Downstream role: consumes the block's single-bit output and compares each sample against a parameterised expected truth table.
- Reports per-row mismatches, a mismatch count, and a pass/done handshake, so gate-level guide exercises self-check in simulation.

Parameters:
- N_IN, 2: number of DUT inputs; rows = 2**N_IN.
- EXPECT, 4'b1001: expected DUT output, width 2**N_IN; bit i is the expected output for input vector i. The default is XNOR.
- SETTLE, 1: clock cycles each vector is held before sampling. Values below 1 are treated as 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to run a full sweep.
- s_in  input  1  DUT output under check.
- vec_out  output  N_IN  DUT input vector; bit 0 drives the DUT's b input, bit 1 drives its a input.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next start or rst.
- pass  output  1  done and zero mismatches.
- err_count  output  N_IN+1  number of mismatching rows; range 0..2**N_IN, never wraps.
- fail_mask  output  2**N_IN  bit i set if row i mismatched.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, row index=0, settle counter=0. This applies in any state, including mid-sweep; the sweep is abandoned with no partial results kept.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE, idx=0, vec_out=0, settle counter=SETTLE, busy=1, err_count=0, fail_mask=0.
  - start=0 -> stay.
- SETTLE:
  - Counter decrements each cycle.
  - Counter reaching 1 -> SAMPLE on the next edge.
  - vec_out is stable throughout.
- SAMPLE (one cycle):
  - Compare s_in with EXPECT[idx]. On mismatch: err_count+1, fail_mask[idx]=1.
  - If idx != 2**N_IN-1: idx+1, vec_out=idx+1, counter=SETTLE, go to SETTLE.
  - Else: go to DONE, busy=0, done=1.
- DONE:
  - pass = (err_count==0); pass is combinational from the registered state and is 0 outside DONE.
  - Results are held.
  - start=1 -> restart exactly as from IDLE; results clear on the same edge.
- Timing:
  - Each row takes SETTLE+1 cycles.
  - start accepted at edge k -> row i is presented from edge k+i*(SETTLE+1) and sampled at edge k+(i+1)*(SETTLE+1)-1.
  - done rises at edge k+2**N_IN*(SETTLE+1). With defaults, done rises 8 edges after start.
- start while busy is ignored; no queuing.
- s_in is sampled only in SAMPLE; glitches during SETTLE are don't-care.
- vec_out is registered, never combinational from idx.

Optional Feature:
- Macro TT_CHECKER_CAPTURE_EN.
- When defined, adds output port observed (width 2**N_IN): bit i holds the s_in value captured in row i's SAMPLE. It clears on start and rst and is held in DONE.
- When undefined, the port and its register are absent; all other behaviour is identical.

Test Plan:
- s_in=~(vec_out[1]^vec_out[0]) (correct XNOR), pulse start -> vec_out steps 0,1,2,3 every 2 cycles; done=1 at edge +8; pass=1, err_count=0, fail_mask=0000.
- s_in tied 0 -> done with err_count=2, fail_mask=1001, pass=0.
- s_in tied 1 -> err_count=2, fail_mask=0110, pass=0.
- start pulsed again at edge +3 of a running sweep -> ignored; done still at edge +8; results unaffected.
- rst=1 while vec_out=2 -> next cycle busy=0, vec_out=0, err_count=0, state IDLE; a later start runs a clean full sweep.
- From DONE with err_count=2, correct DUT, start -> fail_mask and err_count clear on the start edge; final pass=1. With TT_CHECKER_CAPTURE_EN defined, observed=1001.
